// File: rtl/alu32_nibble_seq_pkg.sv
// Shared constants for the nibble-serial 32-bit ALU: 74x381 function codes,
// sequencer states and the nibble count of a 32-bit word.
package alu32_nibble_seq_pkg;

  localparam int NIBBLES = 8;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_BSA = 3'b001;
  localparam logic [2:0] OP_ASB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_SET = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Ops whose final carry/borrow is meaningful on cout.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BSA) || (op == OP_ASB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu32_nibble_seq_74x381.sv
// 4-bit 74x381-equivalent ALU slice. cn is carry-in for add and borrow-in for
// subtract; gn is the active-low carry-out (add) or active-low borrow-out.
module _74x381
  import alu32_nibble_seq_pkg::*;
(
  input  logic [2:0] s_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cn_i,
  output logic [3:0] f_o,
  output logic       gn_o,
  output logic       pn_o
);

  logic [4:0] ext;

  always_comb begin
    ext  = 5'd0;
    f_o  = 4'h0;
    gn_o = 1'b1;
    case (s_i)
      OP_ADD: begin
        ext  = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cn_i};
        f_o  = ext[3:0];
        gn_o = ~ext[4];
      end
      // Bit 4 of the 5-bit difference is the borrow out of this nibble.
      OP_ASB: begin
        ext  = {1'b0, a_i} - {1'b0, b_i} - {4'd0, cn_i};
        f_o  = ext[3:0];
        gn_o = ~ext[4];
      end
      OP_BSA: begin
        ext  = {1'b0, b_i} - {1'b0, a_i} - {4'd0, cn_i};
        f_o  = ext[3:0];
        gn_o = ~ext[4];
      end
      OP_XOR:  f_o = a_i ^ b_i;
      OP_OR:   f_o = a_i | b_i;
      OP_AND:  f_o = a_i & b_i;
      OP_SET:  f_o = 4'hF;
      default: f_o = 4'h0;
    endcase
  end

  assign pn_o = ~&(a_i | b_i);

endmodule

// File: rtl/alu32_nibble_seq.sv
// Nibble-serial 32-bit ALU: one 74x381 slice evaluates nibble 0..7 over eight
// RUN cycles, with the carry/borrow rippled through a register between nibbles.
module alu32_nibble_seq
  import alu32_nibble_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cout,
  output logic        zero
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        cout_q, cout_d;

  logic [4:0]  bit_base;
  logic [3:0]  slice_f;
  logic        slice_gn;
  logic        pn_unused;

  assign bit_base = {idx_q, 2'b00};

  _74x381 u_slice (
    .s_i  (op_q),
    .a_i  (a_q[bit_base +: 4]),
    .b_i  (b_q[bit_base +: 4]),
    .cn_i (carry_q),
    .f_o  (slice_f),
    .gn_o (slice_gn),
    .pn_o (pn_unused)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        // result is deliberately left alone; it is overwritten nibble by nibble.
        if (start) begin
          state_d = ST_RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = 3'd0;
        end
      end
      ST_RUN: begin
        result_d[bit_base +: 4] = slice_f;
        carry_d                 = ~slice_gn;
        idx_d                   = idx_q + 3'd1;
        if (idx_q == 3'(NIBBLES - 1)) begin
          state_d = ST_DONE;
          cout_d  = is_arith(op_q) & ~slice_gn;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      op_q     <= OP_CLR;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = (result_q == 32'd0);

endmodule

// File: tb/tb_alu32_nibble_seq.sv
// Self-checking bench for alu32_nibble_seq: directed corner cases plus random
// ops compared against a whole-word arithmetic reference model.
module tb_alu32_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu32_nibble_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Reference: 33-bit whole-word arithmetic; bit 32 is carry (add) or borrow (sub).
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic c, output logic [31:0] r, output logic co);
    logic [32:0] w;
    w  = '0;
    r  = '0;
    co = 1'b0;
    case (o)
      3'b000: r = 32'h0000_0000;
      3'b001: begin w = {1'b0, y} - {1'b0, x} - 33'(c); r = w[31:0]; co = w[32]; end
      3'b010: begin w = {1'b0, x} - {1'b0, y} - 33'(c); r = w[31:0]; co = w[32]; end
      3'b011: begin w = {1'b0, x} + {1'b0, y} + 33'(c); r = w[31:0]; co = w[32]; end
      3'b100: r = x ^ y;
      3'b101: r = x | y;
      3'b110: r = x & y;
      default: r = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge; the accept edge is the next rising edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic c, input bit poke);
    logic [31:0] er;
    logic        ec;
    int          early;
    early = 0;
    model(o, x, y, c, er, ec);
    start = 1'b1; op = o; a = x; b = y; cin = c;
    @(negedge clk);
    // Operands change during RUN and must have no effect.
    start = 1'b0;
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    op  = 3'($urandom_range(0, 7));
    check("busy_first_run", 32'(busy), 32'd1);
    for (int cyc = 1; cyc < 9; cyc++) begin
      if (done) early++;
      start = poke && (cyc == 3 || cyc == 6);
      @(negedge clk);
    end
    start = 1'b0;
    check("early_done", early, 0);
    check("done_at_9", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("result", result, er);
    check("cout", 32'(cout), 32'(ec));
    check("zero", 32'(zero), 32'(er == 32'd0));
    $display("txn op=%0d a=%08h b=%08h cin=%0d -> result=%08h cout=%0b zero=%0b (exp %08h/%0b)",
             o, x, y, c, result, cout, zero, er, ec);
    @(negedge clk);
    check("done_one_pulse", 32'(done), 32'd0);
    check("no_queued_start", 32'(busy), 32'd0);
    check("result_hold", result, er);
    check("cout_hold", 32'(cout), 32'(ec));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cin = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start accepted in the first cycle after reset release.
    run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(3'b010, 32'd5, 32'd7, 1'b0, 1'b0);
    run_op(3'b001, 32'd5, 32'd7, 1'b0, 1'b0);
    run_op(3'b100, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1'b0);
    run_op(3'b111, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1'b0);
    run_op(3'b000, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1'b0);
    run_op(3'b011, 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0);
    run_op(3'b010, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    // Starts during RUN ignored, not queued, result intact.
    run_op(3'b011, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);

    // Asynchronous reset in the middle of an add (nibble 4 in flight).
    start = 1'b1; op = 3'b011; a = 32'h8765_4321; b = 32'h1111_1111; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    @(posedge clk);
    #1;
    check("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b011, 32'h8765_4321, 32'h1111_1111, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = pick_operand();
      y = pick_operand();
      run_op(3'($urandom_range(0, 7)), x, y, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu32_nibble_seq.md
ALU32_NIBBLE_SEQ -- requirements
Module: alu32_nibble_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 op  input  3  function select, same encoding as the 74x381 s inputs: 000 clear, 001 B-A, 010 A-B, 011 A+B, 100 XOR, 101 OR, 110 AND, 111 preset.
REQ-006 a  input  32  operand A, captured on accept.
REQ-007 b  input  32  operand B, captured on accept.
REQ-008 cin  input  1  carry in (add) or borrow in (subtract), captured on accept.
REQ-009 busy  output  1  high from the accept cycle through the last nibble cycle.
REQ-010 done  output  1  one-cycle pulse; result, cout and zero are valid in that cycle.
REQ-011 result  output  32  operation result.
REQ-012 cout  output  1  final carry out (add) or borrow out (subtract); 0 for all other ops.
REQ-013 zero  output  1  high when result == 0.

Function
REQ-014 The block SHALL evaluate one 4-bit nibble per cycle through a single 74x381-equivalent slice, starting with the least significant nibble (bits 3:0).
REQ-015 The state machine SHALL have three states, IDLE, RUN and DONE, with these transitions:
  - IDLE -> RUN on start.
  - RUN stays in RUN for 8 cycles, nibble index 0..7.
  - RUN -> DONE after nibble 7.
  - DONE -> IDLE unconditionally.
REQ-016 On accept, the block SHALL latch op, a, b and cin, load the carry register with cin, and clear the nibble index to 0.
REQ-017 In each RUN cycle, the block SHALL write the slice output f into result[4i+3:4i] and load the carry register with ~gn.
REQ-018 The carry register SHALL be the slice cn input for the next nibble.
REQ-019 Latency SHALL be fixed: done is high exactly 9 cycles after the accept edge, for every op.
REQ-020 In DONE, cout SHALL equal the carry register for ops 001, 010 and 011, and 0 otherwise.
REQ-021 In DONE, zero SHALL be computed from the full 32-bit result.
REQ-022 Op 000 SHALL produce result 0x00000000; op 111 SHALL produce 0xFFFFFFFF.
REQ-023 Subtraction semantics SHALL be A-B-cin (op 010) and B-A-cin (op 001), modulo 2^32; cout=1 means a borrow occurred.
REQ-024 A start asserted while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 Operand inputs SHALL NOT be sampled after accept; changes during RUN SHALL have no effect.
REQ-026 result, cout and zero SHALL hold their values after done until the next accept.
REQ-027 On accept, result SHALL NOT be cleared; it is overwritten nibble by nibble.

Reset
REQ-028 While rst_n=0, the block SHALL force: state IDLE, busy 0, done 0, result 0x00000000, cout 0, zero 1, carry register 0, nibble index 0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation immediately, with no done pulse.
REQ-030 The block SHALL accept a new start in the first cycle after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold:
  - the op encoding constants (OP_CLR, OP_BSA, OP_ASB, OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SET);
  - the state enumeration;
  - NIBBLES=8.
REQ-032 The block SHALL contain exactly one sub-module: the existing _74x381 slice, instantiated once.
REQ-033 Operand nibbles SHALL be selected from the latched registers by the nibble index.
REQ-034 The pn output of the slice SHALL be left unused.

Verification
REQ-035 op=011, a=0xFFFFFFFF, b=0x00000001, cin=0 -> done 9 cycles after accept, result=0x00000000, cout=1, zero=1.
REQ-036 op=010, a=5, b=7, cin=0 -> result=0xFFFFFFFE, cout=1; then op=001 with the same operands -> result=0x00000002, cout=0.
REQ-037 op=100, a=0xA5A5A5A5, b=0xFFFF0000 -> result=0x5A5AA5A5, cout=0, zero=0; then op=111 -> 0xFFFFFFFF, and op=000 -> 0x00000000 with zero=1.
REQ-038 Start pulsed on cycles 3 and 6 of a RUN -> only one done pulse, and the first operation's result is not corrupted.
REQ-039 rst_n pulsed low at nibble 4 of an add -> outputs match REQ-028 asynchronously, no done pulse, and a new start in the next cycle completes correctly.
REQ-040 op=011, a=0x0000000F, b=0x00000000, cin=1 -> result=0x00000010, confirming the nibble-to-nibble carry chain.
